dft_frame_dispatcher: RTL and testbench

Parametrised ping-pong successor for the mixed-radix DFT top. It distributes whole input frames round-robin across `NUM_CORES` DFT cores and collects their output frames back into a single stream, in the original frame order. Backpressure is applied on both sides, and the output stage is registered. It sits between the system sample interface and the core array, and replaces fixed two-way input/output switches driven by a bare select bit.

---
 rtl/dft_pkg.sv | 7 +
 rtl/order_fifo.sv | 38 +++
 rtl/dft_frame_dispatcher.sv | 127 ++++++++++++
 tb/tb_dft_frame_dispatcher.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dft_pkg.sv
// dft_pkg: shared types and helpers for the DFT frame dispatcher
package dft_pkg;
  typedef enum logic {IN_IDLE, IN_FRAME} in_state_t;
  function automatic int sel_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/order_fifo.sv
// order_fifo: synchronous FIFO of core indices recording frame dispatch order
module order_fifo #(
  parameter int W     = 1,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0]   r_cnt;
  logic          w_push, w_pop;
  assign w_push = push & ~full;
  assign w_pop  = pop & ~empty;
  assign dout   = r_mem[r_rp];
  assign full   = r_cnt == (AW+1)'(DEPTH);
  assign empty  = r_cnt == '0;
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wp] <= din;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop) r_rp <= r_rp + 1'b1;
      r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end
endmodule

// File: rtl/dft_frame_dispatcher.sv
// dft_frame_dispatcher: round-robin frame distribution over NUM_CORES DFT cores
// with in-order, registered collection of their output frames.
module dft_frame_dispatcher
  import dft_pkg::*;
#(
  parameter int wData       = 18,
  parameter int wPts        = 12,
  parameter int NUM_CORES   = 2,
  parameter int ORDER_DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      sink_valid,
  input  logic                      sink_sop,
  input  logic                      sink_eop,
  output logic                      sink_ready,
  input  logic [wData-1:0]          sink_real,
  input  logic [wData-1:0]          sink_imag,
  input  logic [wPts-1:0]           dftpts_in,
  input  logic                      inverse,
  output logic [NUM_CORES-1:0]      core_sink_valid,
  input  logic [NUM_CORES-1:0]      core_sink_ready,
  output logic                      core_sink_sop,
  output logic                      core_sink_eop,
  output logic [wData-1:0]          core_sink_real,
  output logic [wData-1:0]          core_sink_imag,
  output logic [wPts-1:0]           core_dftpts,
  output logic                      core_inverse,
  input  logic [NUM_CORES-1:0]      core_source_valid,
  input  logic [NUM_CORES-1:0]      core_source_sop,
  input  logic [NUM_CORES-1:0]      core_source_eop,
  output logic [NUM_CORES-1:0]      core_source_ready,
  input  logic [NUM_CORES*wData-1:0] core_source_real,
  input  logic [NUM_CORES*wData-1:0] core_source_imag,
  input  logic [NUM_CORES*wPts-1:0]  core_dftpts_out,
  output logic                      source_valid,
  output logic                      source_sop,
  output logic                      source_eop,
  input  logic                      source_ready,
  output logic [wData-1:0]          source_real,
  output logic [wData-1:0]          source_imag,
  output logic [wPts-1:0]           dftpts_out,
  output logic                      drop_pulse
);
  localparam int wSel = sel_w(NUM_CORES);
  localparam logic [wSel-1:0] LAST = wSel'(NUM_CORES - 1);
  in_state_t        r_state;
  logic [wSel-1:0]  r_in_sel;
  logic [wPts-1:0]  r_pts;
  logic             r_inv;
  logic             r_src_valid, r_src_sop, r_src_eop;
  logic [wData-1:0] r_src_real, r_src_imag;
  logic [wPts-1:0]  r_src_pts;
  logic             w_idle, w_full, w_empty, w_drop, w_acc, w_push, w_first;
  logic             w_rd, w_take, w_pop;
  logic [wSel-1:0]  w_out_sel;
  assign w_idle     = r_state == IN_IDLE;
  assign w_drop     = rst_n & w_idle & sink_valid & ~sink_sop;
  // a new frame may only start when the order FIFO can record it
  assign sink_ready = w_drop | (rst_n & core_sink_ready[r_in_sel] & ~(w_idle & w_full));
  assign drop_pulse = w_drop;
  assign w_acc      = sink_valid & sink_ready & ~w_drop;
  assign w_push     = w_acc & w_idle;
  assign w_first    = w_idle & sink_sop;
  assign core_sink_valid = {{(NUM_CORES-1){1'b0}}, w_acc} << r_in_sel;
  assign core_sink_sop   = sink_sop;
  assign core_sink_eop   = sink_eop;
  assign core_sink_real  = sink_real;
  assign core_sink_imag  = sink_imag;
  assign core_dftpts     = w_first ? dftpts_in : r_pts;
  assign core_inverse    = w_first ? inverse : r_inv;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= IN_IDLE;
      r_in_sel <= '0;
      r_pts    <= '0;
      r_inv    <= 1'b0;
    end else if (w_acc) begin
      if (w_push) begin
        r_pts <= dftpts_in;
        r_inv <= inverse;
      end
      r_state <= sink_eop ? IN_IDLE : IN_FRAME;
      if (sink_eop) r_in_sel <= (r_in_sel == LAST) ? '0 : r_in_sel + 1'b1;
    end
  end
  order_fifo #(.W(wSel), .DEPTH(ORDER_DEPTH)) u_order_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (w_push),
    .pop   (w_pop),
    .din   (r_in_sel),
    .dout  (w_out_sel),
    .full  (w_full),
    .empty (w_empty)
  );
  // only the core owning the oldest outstanding frame is allowed to drain
  assign w_rd   = rst_n & ~w_empty & (~r_src_valid | source_ready);
  assign core_source_ready = {{(NUM_CORES-1){1'b0}}, w_rd} << w_out_sel;
  assign w_take = w_rd & core_source_valid[w_out_sel];
  assign w_pop  = w_take & core_source_eop[w_out_sel];
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_src_valid <= 1'b0;
      r_src_sop   <= 1'b0;
      r_src_eop   <= 1'b0;
      r_src_real  <= '0;
      r_src_imag  <= '0;
      r_src_pts   <= '0;
    end else if (w_take) begin
      r_src_valid <= 1'b1;
      r_src_sop   <= core_source_sop[w_out_sel];
      r_src_eop   <= core_source_eop[w_out_sel];
      r_src_real  <= core_source_real[w_out_sel*wData +: wData];
      r_src_imag  <= core_source_imag[w_out_sel*wData +: wData];
      r_src_pts   <= core_dftpts_out[w_out_sel*wPts +: wPts];
    end else if (source_ready) begin
      r_src_valid <= 1'b0;
    end
  end
  assign source_valid = r_src_valid;
  assign source_sop   = r_src_sop;
  assign source_eop   = r_src_eop;
  assign source_real  = r_src_real;
  assign source_imag  = r_src_imag;
  assign dftpts_out   = r_src_pts;
endmodule

// File: tb/tb_dft_frame_dispatcher.sv
// tb_dft_frame_dispatcher: randomized frames through three modelled cores,
// checked against frame-order and round-robin expectations.
module tb_dft_frame_dispatcher;
  localparam int W = 18, P = 12, NC = 3, D = 4;
  typedef struct packed {
    logic [P-1:0] pts;
    logic         sop;
    logic         eop;
    logic [W-1:0] re;
    logic [W-1:0] im;
  } beat_t;
  logic clk = 0, rst_n = 0;
  logic sink_valid = 0, sink_sop = 0, sink_eop = 0, sink_ready;
  logic [W-1:0] sink_real = 0, sink_imag = 0;
  logic [P-1:0] dftpts_in = 0;
  logic inverse = 0;
  logic [NC-1:0] core_sink_valid, core_sink_ready = '1;
  logic core_sink_sop, core_sink_eop, core_inverse;
  logic [W-1:0] core_sink_real, core_sink_imag;
  logic [P-1:0] core_dftpts;
  logic [NC-1:0] core_source_valid = 0, core_source_sop = 0, core_source_eop = 0, core_source_ready;
  logic [NC*W-1:0] core_source_real = 0, core_source_imag = 0;
  logic [NC*P-1:0] core_dftpts_out = 0;
  logic source_valid, source_sop, source_eop, source_ready = 1, drop_pulse;
  logic [W-1:0] source_real, source_imag;
  logic [P-1:0] dftpts_out;
  logic [NC-1:0] ret_en = '1;
  beat_t tx [NC][$];
  beat_t exp_q [$];
  int errs = 0, checks = 0, fcnt = 0;

  dft_frame_dispatcher #(.wData(W), .wPts(P), .NUM_CORES(NC), .ORDER_DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n),
    .sink_valid(sink_valid), .sink_sop(sink_sop), .sink_eop(sink_eop), .sink_ready(sink_ready),
    .sink_real(sink_real), .sink_imag(sink_imag), .dftpts_in(dftpts_in), .inverse(inverse),
    .core_sink_valid(core_sink_valid), .core_sink_ready(core_sink_ready),
    .core_sink_sop(core_sink_sop), .core_sink_eop(core_sink_eop),
    .core_sink_real(core_sink_real), .core_sink_imag(core_sink_imag),
    .core_dftpts(core_dftpts), .core_inverse(core_inverse),
    .core_source_valid(core_source_valid), .core_source_sop(core_source_sop),
    .core_source_eop(core_source_eop), .core_source_ready(core_source_ready),
    .core_source_real(core_source_real), .core_source_imag(core_source_imag),
    .core_dftpts_out(core_dftpts_out),
    .source_valid(source_valid), .source_sop(source_sop), .source_eop(source_eop),
    .source_ready(source_ready), .source_real(source_real), .source_imag(source_imag),
    .dftpts_out(dftpts_out), .drop_pulse(drop_pulse)
  );

  always #5 clk = ~clk;

  // Streaming core model: each core echoes every beat it receives, one beat per cycle.
  always @(negedge clk) begin
    bit pop [NC];
    beat_t b;
    for (int i = 0; i < NC; i++) begin
      pop[i] = rst_n && core_source_valid[i] && core_source_ready[i];
      if (!rst_n) tx[i].delete();
      else if (core_sink_valid[i] && core_sink_ready[i])
        tx[i].push_back({core_dftpts, core_sink_sop, core_sink_eop, core_sink_real, core_sink_imag});
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < NC; i++) begin
      if (pop[i] && tx[i].size() > 0) void'(tx[i].pop_front());
      b = (tx[i].size() > 0) ? tx[i][0] : '0;
      core_source_valid[i] = ret_en[i] && tx[i].size() > 0;
      core_source_sop[i] = b.sop;
      core_source_eop[i] = b.eop;
      core_source_real[i*W +: W] = b.re;
      core_source_imag[i*W +: W] = b.im;
      core_dftpts_out[i*P +: P] = b.pts;
    end
  end

  task automatic apply_reset();
    rst_n = 0; sink_valid = 0; sink_sop = 0; sink_eop = 0; source_ready = 1; ret_en = '1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1; fcnt = 0; exp_q.delete();
  endtask

  task automatic send_frame(input int len, input logic [P-1:0] pts, input logic inv);
    for (int b = 0; b < len; b++) begin
      int t;
      logic [NC-1:0] oh;
      t = 0;
      sink_valid = 1; sink_sop = (b == 0); sink_eop = (b == len - 1);
      sink_real = W'($urandom); sink_imag = W'($urandom);
      dftpts_in = (b == 0) ? pts : P'($urandom);
      inverse = (b == 0) ? inv : 1'($urandom);
      @(negedge clk);
      while (!sink_ready && t < 200) begin
        @(negedge clk);
        t++;
      end
      checks++;
      if (!sink_ready) begin
        errs++;
        $display("FAIL send_timeout: frame %0d beat %0d sink_ready=%0b required 1", fcnt, b, sink_ready);
      end else begin
        oh = '0;
        oh[fcnt % NC] = 1'b1;
        if (core_sink_valid !== oh || core_dftpts !== pts || core_inverse !== inv) begin
          errs++;
          $display("FAIL dispatch: frame %0d beat %0d core_sink_valid=%b pts=%h inv=%b required %b %h %b",
                   fcnt, b, core_sink_valid, core_dftpts, core_inverse, oh, pts, inv);
        end
        exp_q.push_back({pts, sink_sop, sink_eop, sink_real, sink_imag});
      end
      @(posedge clk);
      #1;
    end
    fcnt++;
    sink_valid = 0; sink_sop = 0; sink_eop = 0;
  endtask

  // mode 0: ready held high; mode 1: ready follows 1,0,0,1 per cycle of valid output
  task automatic drain(input int n, input int mode);
    int got, cyc, vc;
    logic held;
    beat_t hb, cur, e;
    got = 0; cyc = 0; vc = 0; held = 0; hb = '0;
    while (got < n && cyc < 3000) begin
      source_ready = (mode == 0) ? 1'b1 : (vc % 4 == 0 || vc % 4 == 3);
      @(negedge clk);
      cur = {dftpts_out, source_sop, source_eop, source_real, source_imag};
      if (held) begin
        checks++;
        if (source_valid !== 1'b1 || cur !== hb) begin
          errs++;
          $display("FAIL stall_hold: valid=%b beat=%h required valid=1 beat=%h", source_valid, cur, hb);
        end
      end
      held = source_valid && !source_ready;
      hb = cur;
      if (source_valid) vc++;
      if (source_valid && source_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errs++;
          $display("FAIL extra_beat: got %h with nothing expected", cur);
        end else begin
          e = exp_q.pop_front();
          if (cur !== e) begin
            errs++;
            $display("FAIL out_beat %0d: got %h required %h", got, cur, e);
          end
        end
        got++;
      end
      cyc++;
      @(posedge clk);
      #1;
    end
    source_ready = 1;
    checks++;
    if (got != n) begin
      errs++;
      $display("FAIL drain_timeout: got %0d beats required %0d", got, n);
    end
  endtask

  task automatic test_reset();
    sink_valid = 1; sink_sop = 0;
    @(negedge clk);
    checks++;
    if (sink_ready !== 0 || drop_pulse !== 0 || core_sink_valid !== 0 || core_source_ready !== 0) begin
      errs++;
      $display("FAIL reset_in: sink_ready=%b drop=%b csv=%b csr=%b required all 0",
               sink_ready, drop_pulse, core_sink_valid, core_source_ready);
    end
    checks++;
    if ({source_valid, source_sop, source_eop, source_real, source_imag, dftpts_out} !== '0) begin
      errs++;
      $display("FAIL reset_out: valid=%b sop=%b eop=%b re=%h im=%h pts=%h required all 0",
               source_valid, source_sop, source_eop, source_real, source_imag, dftpts_out);
    end
    @(posedge clk);
    #1;
    sink_valid = 0;
    rst_n = 1;
  endtask

  task automatic test_in_order();
    apply_reset();
    fork
      for (int f = 0; f < 4; f++) send_frame(4, P'($urandom), 1'($urandom));
      drain(16, 0);
    join
  endtask

  task automatic test_head_order();
    apply_reset();
    ret_en = 3'b110;
    for (int f = 0; f < 3; f++) send_frame(4, P'($urandom), 1'($urandom));
    repeat (5) @(posedge clk);
    @(negedge clk);
    checks++;
    if (core_source_ready !== 3'b001 || source_valid !== 0 || core_source_valid[1] !== 1) begin
      errs++;
      $display("FAIL head_block: csr=%b src_valid=%b core1_valid=%b required 001 0 1",
               core_source_ready, source_valid, core_source_valid[1]);
    end
    @(posedge clk);
    #1;
    ret_en = '1;
    drain(12, 0);
  endtask

  task automatic test_backpressure();
    int lens [3];
    int total;
    apply_reset();
    total = 0;
    foreach (lens[i]) begin
      lens[i] = $urandom_range(1, 5);
      total += lens[i];
    end
    fork
      foreach (lens[i]) send_frame(lens[i], P'($urandom), 1'($urandom));
      drain(total, 1);
    join
  endtask

  task automatic test_drop();
    apply_reset();
    sink_valid = 1; sink_sop = 0; sink_eop = 0;
    @(negedge clk);
    checks++;
    if (sink_ready !== 1 || drop_pulse !== 1 || core_sink_valid !== 0) begin
      errs++;
      $display("FAIL drop: sink_ready=%b drop=%b csv=%b required 1 1 000", sink_ready, drop_pulse, core_sink_valid);
    end
    @(posedge clk);
    #1;
    sink_valid = 0;
    @(negedge clk);
    checks++;
    if (drop_pulse !== 0) begin
      errs++;
      $display("FAIL drop_pulse_len: drop=%b required 0", drop_pulse);
    end
    @(posedge clk);
    #1;
    fork
      send_frame(3, P'($urandom), 1'($urandom));
      drain(3, 0);
    join
  endtask

  task automatic test_fifo_full();
    apply_reset();
    ret_en = '0;
    send_frame(4, P'($urandom), 1'($urandom));
    send_frame(3, P'($urandom), 1'($urandom));
    send_frame(1, P'($urandom), 1'($urandom));
    send_frame(4, P'($urandom), 1'($urandom));
    sink_valid = 1; sink_sop = 1; sink_eop = 0;
    @(negedge clk);
    checks++;
    if (sink_ready !== 0 || core_sink_valid !== 0 || drop_pulse !== 0) begin
      errs++;
      $display("FAIL fifo_full: sink_ready=%b csv=%b drop=%b required 0 000 0", sink_ready, core_sink_valid, drop_pulse);
    end
    @(posedge clk);
    #1;
    sink_valid = 0; sink_sop = 0;
    ret_en = '1;
    fork
      send_frame(2, P'($urandom), 1'($urandom));
      drain(14, 0);
    join
  endtask

  task automatic test_reset_mid();
    apply_reset();
    for (int b = 0; b < 2; b++) begin
      sink_valid = 1; sink_sop = (b == 0); sink_eop = 0;
      sink_real = W'($urandom); sink_imag = W'($urandom); dftpts_in = P'($urandom);
      @(negedge clk);
      checks++;
      if (sink_ready !== 1) begin
        errs++;
        $display("FAIL mid_beat %0d: sink_ready=%b required 1", b, sink_ready);
      end
      @(posedge clk);
      #1;
    end
    rst_n = 0;
    @(negedge clk);
    checks++;
    if (sink_ready !== 0 || core_sink_valid !== 0) begin
      errs++;
      $display("FAIL mid_reset_in: sink_ready=%b csv=%b required 0 000", sink_ready, core_sink_valid);
    end
    @(posedge clk);
    #1;
    sink_valid = 0;
    @(negedge clk);
    checks++;
    if (source_valid !== 0 || sink_ready !== 0) begin
      errs++;
      $display("FAIL mid_reset_out: source_valid=%b sink_ready=%b required 0 0", source_valid, sink_ready);
    end
    @(posedge clk);
    #1;
    rst_n = 1; fcnt = 0; exp_q.delete();
    fork
      send_frame(4, P'($urandom), 1'($urandom));
      drain(4, 0);
    join
  endtask

  initial begin
    @(posedge clk);
    #1;
    test_reset();
    test_in_order();
    test_head_order();
    test_backpressure();
    test_drop();
    test_fifo_full();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
